boot_load_ctrl: RTL and testbench
=================================

Name: boot_load_ctrl

Overview:
Boot-time sequencer for the single-cycle RISC-V core.
- Holds the core in reset and streams a program image into main memory. The image arrives as bytes over a valid/ready byte channel and is packed big-endian into 32-bit words.
- When the programmed word count has been written, drives main-memory enable and releases core reset after a fixed delay.
- Sits between the external loader/bench and the Core's clock/reset/mem_en inputs plus the memory write port. It replaces hand-poking of memory bytes.

Parameters:
- BASE_ADDR, 0, byte address of the first loaded word.
- MAX_WORDS, 256, maximum image length in words.
- RELEASE_DLY, 2, cycles between the last write and core_reset deassertion (min 1).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low
- start  in  1  one-cycle pulse: begin a load of load_len words
- load_len  in  16  image length in words; sampled on start
- byte_valid  in  1  byte channel valid
- byte_data  in  8  byte channel data, MSB-first per word
- byte_ready  out  1  byte channel ready
- mem_we  out  1  word write strobe to main memory
- mem_addr  out  32  byte address of the write (word aligned)
- mem_wdata  out  32  packed word
- mem_en  out  1  main-memory enable to the core
- core_reset  out  1  active-high reset to the core
- busy  out  1  load in progress
- done  out  1  core released and running
- error  out  1  bad length; sticky until the next reset or start

Behaviour:
- Reset (reset==0 at a clk edge) drives:
  - State IDLE.
  - byte_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, mem_en=1, core_reset=1, busy=0, done=0, error=0.
  - Byte and word counters cleared.
- Reset mid-load aborts immediately. Already-written words are not undone.
- IDLE:
  - core_reset=1.
  - start with 1<=load_len<=MAX_WORDS: latch the length, clear the counters and error, go to RECV. busy=1 from the next cycle.
  - start with load_len==0 or load_len>MAX_WORDS: go to ERR.
- RECV:
  - byte_ready=1.
  - Each cycle with byte_valid&&byte_ready, the byte goes into the assembly register, first byte of a word into [31:24] and fourth into [7:0], and the byte counter increments (0..3).
  - On the 4th accepted byte, go to WRITE.
- WRITE (exactly 1 cycle):
  - byte_ready=0, mem_we=1, mem_addr=BASE_ADDR+4*word_idx, mem_wdata=assembled word.
  - Then increment word_idx.
  - word_idx+1==len: go to DRAIN. Otherwise back to RECV.
- DRAIN:
  - Count RELEASE_DLY cycles with core_reset=1 and mem_we=0, then go to RUN.
- RUN:
  - core_reset=0, done=1, busy=0, byte_ready=0.
  - start is ignored. Leaving RUN requires reset.
- ERR:
  - error=1, core_reset=1, busy=0.
  - A new valid start re-enters RECV and clears error.
- Byte-channel rules:
  - Bytes offered when byte_ready=0 are not consumed.
  - byte_valid may drop mid-word. The partial word is retained indefinitely; there is no timeout.
- start while busy is ignored.
- Latency: last byte accepted -> mem_we in the next cycle -> core_reset falls RELEASE_DLY+1 cycles after the write cycle.
- Arithmetic:
  - word_idx is 16-bit.
  - Address = BASE_ADDR + {word_idx,2'b00}, zero-extended to 32 bits and wrapping mod 2^32.
- mem_en stays 1 in all states. The memory must be writable during load.

Decomposition:
- Shared package boot_load_pkg:
  - State enum (IDLE, RECV, WRITE, DRAIN, RUN, ERR).
  - WORD_BYTES=4.
  - Default-length constants.
- One natural sub-module: byte_packer. It contains the 2-bit byte counter and the 32-bit big-endian shift/assembly register, with word_valid output. The FSM, address generation and release counter stay in boot_load_ctrl.

Test Plan:
- Reset, then start with load_len=3 and bytes 00 00 00 00 06 40 0A 13 FE CA 0A 93 streamed back-to-back. Required:
  - Writes (0x0,0x00000000), (0x4,0x06400A13), (0x8,0xFECA0A93) in that order, one cycle each.
  - core_reset falls exactly RELEASE_DLY+1 cycles after the last write. done=1.
- Same image with byte_valid toggling 1-0-1-0: identical writes. No byte is lost or duplicated. byte_ready is 0 during each WRITE cycle.
- start with load_len=0, and separately with load_len=MAX_WORDS+1: error=1, no mem_we, core_reset stays 1. A following valid start clears error and the load proceeds.
- reset asserted after 6 bytes of a 2-word load: all outputs return to reset values next cycle. A fresh load then writes word 0 at BASE_ADDR=0 again.
- BASE_ADDR=0x100, load_len=MAX_WORDS: the last write is at address 0x100+4*(MAX_WORDS-1). A start pulse during the load has no effect.
- In RUN, further start pulses and byte_valid: no writes, byte_ready=0, core_reset stays 0.

Source files
------------

// File: rtl/boot_load_ctrl_pkg.sv
// Shared types and constants for the boot loader: FSM state encoding,
// word geometry and default sizing.
package boot_load_pkg;
  typedef enum logic [2:0] {IDLE, RECV, WRITE, DRAIN, RUN, ERR} state_t;

  localparam int          WORD_BYTES      = 4;
  localparam logic [31:0] DEF_BASE_ADDR   = 32'h0;
  localparam int          DEF_MAX_WORDS   = 256;
  localparam int          DEF_RELEASE_DLY = 2;
endpackage

// File: rtl/boot_load_ctrl_if.sv
// Byte-stream input channel plus main-memory write port of the boot loader.
interface boot_load_ctrl_if;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport master (output byte_valid, byte_data,
                  input  byte_ready, mem_we, mem_addr, mem_wdata);
  modport slave  (input  byte_valid, byte_data,
                  output byte_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/boot_load_ctrl_byte_packer.sv
// Big-endian byte-to-word assembler: first byte of a word lands in [31:24].
module byte_packer
  import boot_load_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        accept,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_valid
);
  logic [1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      cnt  <= '0;
      word <= '0;
    end else if (accept) begin
      cnt  <= cnt + 2'd1;
      word <= {word[23:0], data};
    end
  end

  // High in the cycle the final byte of a word is taken.
  assign word_valid = accept && (cnt == 2'(WORD_BYTES - 1));
endmodule

// File: rtl/boot_load_ctrl.sv
// Boot sequencer: holds the core in reset, streams the image into memory
// word by word, then releases core reset after a fixed drain delay.
module boot_load_ctrl
  import boot_load_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter int          MAX_WORDS   = DEF_MAX_WORDS,
  parameter int          RELEASE_DLY = DEF_RELEASE_DLY
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [15:0]      load_len,
  boot_load_ctrl_if.slave  bus,
  output logic             mem_en,
  output logic             core_reset,
  output logic             busy,
  output logic             done,
  output logic             error
);
  localparam logic [15:0] DLY_LAST = 16'(RELEASE_DLY - 1);

  state_t      state, nxt;
  logic [15:0] len, word_idx, dcnt;
  logic        len_ok, clr, rdy, we, accept, word_valid;
  logic [31:0] word;

  assign len_ok = (load_len != 16'd0) && ({16'd0, load_len} <= 32'(MAX_WORDS));
  assign accept = bus.byte_valid && rdy;

  byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clr        (clr),
    .accept     (accept),
    .data       (bus.byte_data),
    .word       (word),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      len      <= '0;
      word_idx <= '0;
      dcnt     <= '0;
    end else begin
      state <= nxt;
      if (clr) begin
        len      <= load_len;
        word_idx <= '0;
      end else if (state == WRITE) begin
        word_idx <= word_idx + 16'd1;
      end
      dcnt <= (state == DRAIN) ? dcnt + 16'd1 : '0;
    end
  end

  always_comb begin
    nxt        = state;
    clr        = 1'b0;
    rdy        = 1'b0;
    we         = 1'b0;
    core_reset = 1'b1;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    unique case (state)
      IDLE, ERR: begin
        error = (state == ERR);
        // Once busy, start is ignored because only these states look at it.
        if (start) begin
          if (len_ok) begin
            nxt = RECV;
            clr = 1'b1;
          end else begin
            nxt = ERR;
          end
        end
      end
      RECV: begin
        rdy  = 1'b1;
        busy = 1'b1;
        if (word_valid) nxt = WRITE;
      end
      WRITE: begin
        we   = 1'b1;
        busy = 1'b1;
        nxt  = ((word_idx + 16'd1) == len) ? DRAIN : RECV;
      end
      DRAIN: begin
        busy = 1'b1;
        if (dcnt == DLY_LAST) nxt = RUN;
      end
      RUN: begin
        core_reset = 1'b0;
        done       = 1'b1;
      end
      default: nxt = IDLE;
    endcase
  end

  assign bus.byte_ready = rdy;
  assign bus.mem_we     = we;
  assign bus.mem_addr   = BASE_ADDR + {14'd0, word_idx, 2'b00};
  assign bus.mem_wdata  = word;
  assign mem_en         = 1'b1;
endmodule

// File: tb/tb_boot_load_ctrl.sv
// Directed bench for boot_load_ctrl: two instances (default base and a
// relocated, short-image variant) sharing one byte stream driver.
module tb_boot_load_ctrl;
  logic        clk = 1'b0;
  logic        rst0, rst1, start, bv;
  logic [15:0] load_len;
  logic [7:0]  bd;
  logic        sel;
  int          nchk = 0, nerr = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  boot_load_ctrl_if if0 ();
  boot_load_ctrl_if if1 ();
  assign if0.byte_valid = bv;
  assign if0.byte_data  = bd;
  assign if1.byte_valid = bv;
  assign if1.byte_data  = bd;

  logic mem_en0, core_reset0, busy0, done0, error0;
  logic mem_en1, core_reset1, busy1, done1, error1;

  boot_load_ctrl dut0 (
    .clk(clk), .reset(rst0), .start(start), .load_len(load_len), .bus(if0),
    .mem_en(mem_en0), .core_reset(core_reset0), .busy(busy0), .done(done0), .error(error0)
  );

  boot_load_ctrl #(.BASE_ADDR(32'h100), .MAX_WORDS(8), .RELEASE_DLY(2)) dut1 (
    .clk(clk), .reset(rst1), .start(start), .load_len(load_len), .bus(if1),
    .mem_en(mem_en1), .core_reset(core_reset1), .busy(busy1), .done(done1), .error(error1)
  );

  logic [31:0] wa0[$], wd0[$], wa1[$], wd1[$];
  int          wc0[$], wc1[$];
  int          brw0 = 0, fall0 = 0, fall1 = 0;
  logic        cr0_q = 1'b1, cr1_q = 1'b1;

  always @(negedge clk) begin
    if (if0.mem_we === 1'b1) begin
      wa0.push_back(if0.mem_addr);
      wd0.push_back(if0.mem_wdata);
      wc0.push_back(cyc);
      if (if0.byte_ready !== 1'b0) brw0 <= brw0 + 1;
    end
    if (if1.mem_we === 1'b1) begin
      wa1.push_back(if1.mem_addr);
      wd1.push_back(if1.mem_wdata);
      wc1.push_back(cyc);
    end
    cr0_q <= core_reset0;
    cr1_q <= core_reset1;
    if (cr0_q === 1'b1 && core_reset0 === 1'b0) fall0 <= cyc;
    if (cr1_q === 1'b1 && core_reset1 === 1'b0) fall1 <= cyc;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy();
    return sel ? if1.byte_ready : if0.byte_ready;
  endfunction

  function automatic logic is_done();
    return sel ? done1 : done0;
  endfunction

  // All send/start tasks are entered and left at a negedge.
  task automatic send(input logic [7:0] b, input bit gap);
    int t = 0;
    bv = 1'b1;
    bd = b;
    while (rdy() !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("byte_accept", rdy(), 1'b1);
    @(negedge clk);
    bv = 1'b0;
    if (gap) @(negedge clk);
  endtask

  task automatic pulse_start(input logic [15:0] n);
    start    = 1'b1;
    load_len = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int t = 0;
    while (is_done() !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk(tag, is_done(), 1'b1);
  endtask

  task automatic reset0();
    bv   = 1'b0;
    rst0 = 1'b0;
    @(negedge clk);
    chk("rst_ready", if0.byte_ready, 1'b0);
    chk("rst_we", if0.mem_we, 1'b0);
    chk("rst_addr", if0.mem_addr, 32'h0);
    chk("rst_wdata", if0.mem_wdata, 32'h0);
    chk("rst_flags", {mem_en0, core_reset0, busy0, done0, error0}, 5'b11000);
    rst0 = 1'b1;
  endtask

  task automatic clear_q();
    wa0.delete(); wd0.delete(); wc0.delete();
    wa1.delete(); wd1.delete(); wc1.delete();
  endtask

  logic [7:0]  img[12] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h06, 8'h40, 8'h0A, 8'h13,
                           8'hFE, 8'hCA, 8'h0A, 8'h93};
  logic [31:0] exp_w[3] = '{32'h00000000, 32'h06400A13, 32'hFECA0A93};

  task automatic check_image(input string tag);
    chk({tag, "_nwr"}, 64'(wa0.size()), 64'd3);
    if (wa0.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        chk({tag, "_addr"}, wa0[i], 32'(4 * i));
        chk({tag, "_data"}, wd0[i], exp_w[i]);
      end
      chk({tag, "_release"}, 64'(fall0 - wc0[2]), 64'd3);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    sel = 1'b0; rst0 = 1'b0; rst1 = 1'b0; start = 1'b0; load_len = '0; bv = 1'b0; bd = '0;
    repeat (2) @(negedge clk);
    reset0();

    // Back-to-back 3-word image
    clear_q();
    pulse_start(16'd3);
    chk("busy_after_start", busy0, 1'b1);
    for (int i = 0; i < 12; i++) send(img[i], 1'b0);
    wait_done("done_b2b");
    @(negedge clk);
    check_image("b2b");
    chk("run_core_reset", core_reset0, 1'b0);

    // RUN ignores start and bytes
    clear_q();
    start = 1'b1; load_len = 16'd2;
    @(negedge clk);
    start = 1'b0;
    bv = 1'b1; bd = 8'h55;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("run_ready", if0.byte_ready, 1'b0);
      chk("run_core_reset", core_reset0, 1'b0);
    end
    bv = 1'b0;
    chk("run_no_wr", 64'(wa0.size()), 64'd0);
    chk("run_done", {done0, busy0}, 2'b10);

    // Same image with valid toggling
    reset0();
    clear_q();
    brw0 = 0;
    pulse_start(16'd3);
    for (int i = 0; i < 12; i++) send(img[i], 1'b1);
    wait_done("done_toggle");
    @(negedge clk);
    check_image("toggle");
    chk("ready_in_write", 64'(brw0), 64'd0);

    // Bad lengths, then recovery
    reset0();
    clear_q();
    pulse_start(16'd0);
    chk("err_len0", {error0, core_reset0, busy0}, 3'b110);
    repeat (3) @(negedge clk);
    chk("err_sticky", error0, 1'b1);
    pulse_start(16'd257);
    chk("err_len_max1", {error0, core_reset0, busy0}, 3'b110);
    chk("err_no_wr", 64'(wa0.size()), 64'd0);
    pulse_start(16'd2);
    chk("err_cleared", {error0, busy0}, 2'b01);

    // Abort after 6 bytes of a 2-word load
    for (int i = 0; i < 6; i++) send(8'(8'h10 + i), 1'b0);
    chk("abort_one_wr", 64'(wa0.size()), 64'd1);
    reset0();
    clear_q();
    pulse_start(16'd1);
    send(8'hAA, 1'b0); send(8'hBB, 1'b0); send(8'hCC, 1'b0); send(8'hDD, 1'b0);
    wait_done("done_fresh");
    chk("fresh_nwr", 64'(wa0.size()), 64'd1);
    if (wa0.size() == 1) begin
      chk("fresh_addr", wa0[0], 32'h0);
      chk("fresh_data", wd0[0], 32'hAABBCCDD);
    end

    // Relocated instance, full-length image with a stray start mid-load
    clear_q();
    sel  = 1'b1;
    rst1 = 1'b1;
    @(negedge clk);
    pulse_start(16'd8);
    for (int w = 0; w < 8; w++) begin
      for (int k = 0; k < 4; k++) begin
        send(8'(4 * w + k + 1), 1'b0);
        if (w == 2 && k == 1) pulse_start(16'd5);
      end
    end
    wait_done("done_max");
    @(negedge clk);
    chk("max_nwr", 64'(wa1.size()), 64'd8);
    if (wa1.size() == 8) begin
      chk("max_first_addr", wa1[0], 32'h100);
      chk("max_last_addr", wa1[7], 32'h11C);
      chk("max_last_data", wd1[7], 32'h1D1E1F20);
      chk("max_release", 64'(fall1 - wc1[7]), 64'd3);
    end
    chk("dut0_idle_in_run", 64'(wa0.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
